// File: rtl/gpio_v2_pkg.sv
// Shared definitions for the gpio_v2 peripheral: register offsets, pin modes,
// interrupt edge types and the pin-count ceiling.
package gpio_v2_pkg;

  localparam int unsigned NUM_IO_MAX = 16;

  typedef enum logic [4:0] {
    OFF_CTRL     = 5'h00,
    OFF_DATA     = 5'h04,
    OFF_SET      = 5'h08,
    OFF_CLR      = 5'h0C,
    OFF_IRQ_EN   = 5'h10,
    OFF_IRQ_TYPE = 5'h14,
    OFF_IRQ_PEND = 5'h18
  } reg_off_e;

  typedef enum logic [1:0] {
    MODE_HIZ  = 2'b00,
    MODE_OUT  = 2'b01,
    MODE_IN   = 2'b10,
    MODE_RSVD = 2'b11
  } pin_mode_e;

  typedef enum logic [1:0] {
    IRQ_RISE = 2'b00,
    IRQ_FALL = 2'b01,
    IRQ_BOTH = 2'b10,
    IRQ_OFF  = 2'b11
  } irq_type_e;

  function automatic logic irq_edge_hit(logic [1:0] irq_type, logic rise, logic fall);
    case (irq_type)
      IRQ_RISE: return rise;
      IRQ_FALL: return fall;
      IRQ_BOTH: return rise | fall;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/gpio_v2_if.sv
// Slave-bus connection of the GPIO: write strobe, address, write and read data.
interface gpio_v2_if;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] data_i;
  logic [31:0] data_o;

  modport master (output we_i, output addr_i, output data_i, input data_o);
  modport slave  (input we_i, input addr_i, input data_i, output data_o);
endinterface

// File: rtl/gpio_sync_edge.sv
// Per-pin input synchroniser with a history flop and rise/fall detection.
module gpio_sync_edge #(
  parameter int unsigned NUM_IO      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_IO-1:0] pin_i,
  output logic [NUM_IO-1:0] sync_o,
  output logic [NUM_IO-1:0] rise_o,
  output logic [NUM_IO-1:0] fall_o
);

  logic [NUM_IO-1:0] s_q [SYNC_STAGES];
  logic [NUM_IO-1:0] h_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) s_q[i] <= '0;
      h_q <= '0;
    end else begin
      s_q[0] <= pin_i;
      for (int unsigned i = 1; i < SYNC_STAGES; i++) s_q[i] <= s_q[i-1];
      h_q <= s_q[SYNC_STAGES-1];
    end
  end

  assign sync_o = s_q[SYNC_STAGES-1];
  assign rise_o = sync_o & ~h_q;
  assign fall_o = ~sync_o & h_q;

endmodule

// File: rtl/gpio_v2.sv
// Parametrised GPIO: per-pin mode, synchronised inputs, atomic set/clear,
// and per-pin edge interrupts combined onto one irq line.
module gpio_v2
  import gpio_v2_pkg::*;
#(
  parameter int unsigned NUM_IO      = 10,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  gpio_v2_if.slave          bus,
  input  logic [NUM_IO-1:0] io_pin_i,
  output logic [NUM_IO-1:0] io_out_o,
  output logic [NUM_IO-1:0] io_oe_o,
  output logic [31:0]       reg_ctrl,
  output logic              irq_o
);

  logic [2*NUM_IO-1:0] ctrl_q, ctrl_d, type_q, type_d;
  logic [NUM_IO-1:0]   data_q, data_d, en_q, en_d, pend_q, pend_d;
  logic [NUM_IO-1:0]   sync, rise, fall, in_mode, hit, wbits;
  logic                unused_bus;

  gpio_sync_edge #(
    .NUM_IO      (NUM_IO),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .pin_i  (io_pin_i),
    .sync_o (sync),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    in_mode = '0;
    io_oe_o = '0;
    hit     = '0;
    for (int unsigned i = 0; i < NUM_IO; i++) begin
      in_mode[i] = (ctrl_q[2*i +: 2] == MODE_IN);
      io_oe_o[i] = (ctrl_q[2*i +: 2] == MODE_OUT);
      hit[i]     = in_mode[i] & irq_edge_hit(type_q[2*i +: 2], rise[i], fall[i]);
    end
  end

  assign wbits = bus.data_i[NUM_IO-1:0];

  always_comb begin
    ctrl_d = ctrl_q;
    type_d = type_q;
    en_d   = en_q;
    data_d = data_q;
    pend_d = pend_q;
    if (bus.we_i) begin
      case (bus.addr_i[4:0])
        OFF_CTRL:     ctrl_d = bus.data_i[2*NUM_IO-1:0];
        OFF_DATA:     data_d = wbits;
        OFF_SET:      data_d = data_q | wbits;
        OFF_CLR:      data_d = data_q & ~wbits;
        OFF_IRQ_EN:   en_d   = wbits;
        OFF_IRQ_TYPE: type_d = bus.data_i[2*NUM_IO-1:0];
        OFF_IRQ_PEND: pend_d = pend_q & ~wbits;
        default:      ;
      endcase
    end
    // Input-mode bits always track the synchroniser; a new edge beats W1C.
    data_d = (data_d & ~in_mode) | (sync & in_mode);
    pend_d = pend_d | hit;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctrl_q <= '0;
      type_q <= '0;
      en_q   <= '0;
      data_q <= '0;
      pend_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
      type_q <= type_d;
      en_q   <= en_d;
      data_q <= data_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    reg_ctrl = '0;
    reg_ctrl[2*NUM_IO-1:0] = ctrl_q;
  end

  always_comb begin
    bus.data_o = '0;
    case (bus.addr_i[4:0])
      OFF_CTRL:     bus.data_o = reg_ctrl;
      OFF_DATA:     bus.data_o[NUM_IO-1:0] = data_q;
      OFF_IRQ_EN:   bus.data_o[NUM_IO-1:0] = en_q;
      OFF_IRQ_TYPE: bus.data_o[2*NUM_IO-1:0] = type_q;
      OFF_IRQ_PEND: bus.data_o[NUM_IO-1:0] = pend_q;
      default:      ;
    endcase
  end

  assign io_out_o   = data_q;
  assign irq_o      = |(pend_q & en_q);
  assign unused_bus = ^{bus.addr_i[31:5], bus.data_i};

endmodule

// File: tb/tb_gpio_v2.sv
// Directed and randomised checks of gpio_v2 against a pin-history reference model.
`timescale 1ns/100ps
module tb_gpio_v2;

  localparam int unsigned N = 10;
  localparam int unsigned S = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  io_pin = '0;
  logic [N-1:0]  io_out, io_oe;
  logic [31:0]   reg_ctrl;
  logic          irq;

  gpio_v2_if bus ();

  gpio_v2 #(.NUM_IO(N), .SYNC_STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .io_pin_i (io_pin),
    .io_out_o (io_out),
    .io_oe_o  (io_oe),
    .reg_ctrl (reg_ctrl),
    .irq_o    (irq)
  );

  always #10 clk = ~clk;

  // Reference model: pin modes/types as integers, pin samples as a history queue.
  int           m_mode [N];
  int           m_type [N];
  bit           m_data [N];
  bit           m_en   [N];
  bit           m_pend [N];
  bit [N-1:0]   phist [$];
  int           n_checks = 0;
  int           n_fail   = 0;

  function automatic void m_reset();
    for (int i = 0; i < N; i++) begin
      m_mode[i] = 0; m_type[i] = 0; m_data[i] = 0; m_en[i] = 0; m_pend[i] = 0;
    end
    phist.delete();
  endfunction

  function automatic void m_edge(logic we, logic [31:0] addr, logic [31:0] wd, logic [N-1:0] pins);
    bit [N-1:0] nv = '0;
    bit [N-1:0] ov = '0;
    int         off;
    phist.push_front(pins);
    if (phist.size() > S + 2) void'(phist.pop_back());
    if (phist.size() > S)     nv = phist[S];
    if (phist.size() > S + 1) ov = phist[S+1];
    off = int'(addr[4:0]);
    for (int i = 0; i < N; i++) begin
      bit r, f, e;
      r = nv[i] && !ov[i];
      f = !nv[i] && ov[i];
      e = (m_mode[i] == 2) && ((m_type[i] == 0 && r) || (m_type[i] == 1 && f) ||
                               (m_type[i] == 2 && (r || f)));
      if (m_mode[i] == 2)                        m_data[i] = nv[i];
      else if (we && off == 4)                   m_data[i] = wd[i];
      else if (we && off == 8 && wd[i] == 1'b1)  m_data[i] = 1;
      else if (we && off == 12 && wd[i] == 1'b1) m_data[i] = 0;
      if (e)                                     m_pend[i] = 1;
      else if (we && off == 24 && wd[i] == 1'b1) m_pend[i] = 0;
    end
    if (we) begin
      for (int i = 0; i < N; i++) begin
        if (off == 0)  m_mode[i] = int'(wd[2*i +: 2]);
        if (off == 16) m_en[i]   = wd[i];
        if (off == 20) m_type[i] = int'(wd[2*i +: 2]);
      end
    end
  endfunction

  function automatic logic [31:0] m_read(int off);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) begin
      case (off)
        0:  v[2*i +: 2] = 2'(m_mode[i]);
        4:  v[i] = m_data[i];
        16: v[i] = m_en[i];
        20: v[2*i +: 2] = 2'(m_type[i]);
        24: v[i] = m_pend[i];
        default: ;
      endcase
    end
    return v;
  endfunction

  function automatic logic [31:0] m_oe();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = (m_mode[i] == 1);
    return v;
  endfunction

  function automatic logic [31:0] m_irq();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) if (m_pend[i] && m_en[i]) v = 32'd1;
    return v;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("io_out",   32'(io_out), m_read(4));
    chk("io_oe",    32'(io_oe),  m_oe());
    chk("irq",      32'(irq),    m_irq());
    chk("reg_ctrl", reg_ctrl,    m_read(0));
  endtask

  task automatic read_all();
    logic [31:0] r;
    bus.we_i = 1'b0;
    for (int k = 0; k < 8; k++) begin
      r = $urandom;
      bus.addr_i = {r[31:5], 5'(k*4)};
      #1;
      chk($sformatf("read_%02h", k*4), bus.data_o, m_read(k*4));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_edge(bus.we_i, bus.addr_i, bus.data_i, io_pin);
    #1;
    check_outputs();
    read_all();
  endtask

  task automatic idle();
    bus.we_i = 1'b0;
    tick();
  endtask

  task automatic wr(logic [4:0] off, logic [31:0] d);
    logic [31:0] r;
    r = $urandom;
    bus.we_i   = 1'b1;
    bus.addr_i = {r[31:5], off};
    bus.data_i = d;
    tick();
  endtask

  task automatic peek(logic [4:0] off, string tag, logic [31:0] exp);
    bus.we_i   = 1'b0;
    bus.addr_i = {27'd0, off};
    #1;
    chk(tag, bus.data_o, exp);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [4:0]  off;
    bus.we_i = 1'b0; bus.addr_i = '0; bus.data_i = '0;
    m_reset();
    #25;
    check_outputs();
    read_all();
    chk("reset_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    idle();

    // All pins output, SET then CLR
    wr(5'h00, 32'h0005_5555);
    wr(5'h08, 32'h005);
    wr(5'h0C, 32'h001);
    chk("setclr_out", 32'(io_out), 32'h004);
    chk("setclr_oe",  32'(io_oe),  32'h3FF);
    peek(5'h04, "setclr_data", 32'h004);

    // Input latency on pin 0
    wr(5'h00, 32'h2);
    idle(); idle();
    io_pin[0] = 1'b1;
    idle();
    chk("lat_k",  32'(io_out[0]), 32'd0);
    idle();
    chk("lat_k1", 32'(io_out[0]), 32'd0);
    idle();
    chk("lat_k2", 32'(io_out[0]), 32'd1);
    wr(5'h04, 32'h0);
    chk("input_data_write_ignored", 32'(io_out[0]), 32'd1);

    // Rising-edge interrupt on pin 3
    wr(5'h18, 32'h3FF);
    wr(5'h14, 32'h0);
    wr(5'h10, 32'h8);
    wr(5'h00, 32'h80);
    io_pin[3] = 1'b1;
    idle();
    chk("rise_irq_k", 32'(irq), 32'd0);
    idle();
    chk("rise_irq_k1", 32'(irq), 32'd0);
    io_pin[3] = 1'b0;
    idle();
    chk("rise_irq_k2", 32'(irq), 32'd1);
    peek(5'h18, "rise_pend", 32'h008);
    wr(5'h18, 32'h8);
    chk("w1c_irq", 32'(irq), 32'd0);

    // Set wins over W1C on pin 2 (both edges)
    wr(5'h00, 32'h20);
    wr(5'h14, 32'h20);
    io_pin[2] = 1'b1;
    idle(); idle(); idle();
    peek(5'h18, "both_rise_pend", 32'h004);
    io_pin[2] = 1'b0;
    idle(); idle();
    wr(5'h18, 32'h4);
    peek(5'h18, "set_wins_pend", 32'h004);
    wr(5'h18, 32'h4);
    peek(5'h18, "w1c_clears_pend", 32'h000);

    // Hi-Z pin masked, input pin with IRQ_EN off
    wr(5'h00, 32'h2000);
    wr(5'h10, 32'h0);
    wr(5'h14, 32'h0);
    io_pin[5] = 1'b1;
    io_pin[6] = 1'b1;
    idle(); idle(); idle();
    peek(5'h18, "mask_pend", 32'h040);
    chk("mask_irq_off", 32'(irq), 32'd0);
    wr(5'h10, 32'h40);
    chk("mask_irq_on", 32'(irq), 32'd1);

    // Asynchronous reset mid-run
    wr(5'h00, 32'h0005_5555);
    wr(5'h04, 32'h3FF);
    chk("pre_reset_out", 32'(io_out), 32'h3FF);
    #2;
    rst = 1'b0;
    #1;
    chk("async_rst_out",  32'(io_out), 32'h0);
    chk("async_rst_oe",   32'(io_oe),  32'h0);
    chk("async_rst_irq",  32'(irq),    32'h0);
    chk("async_rst_ctrl", reg_ctrl,    32'h0);
    m_reset();
    read_all();
    @(negedge clk);
    rst = 1'b1;

    // Randomised traffic
    for (int n = 0; n < 500; n++) begin
      if ($urandom_range(3) == 0) io_pin = io_pin ^ N'($urandom & $urandom & $urandom);
      if ($urandom_range(2) == 0) begin
        r = $urandom;
        off = ($urandom_range(8) == 8) ? r[4:0] : 5'($urandom_range(6) * 4);
        wr(off, $urandom);
      end else begin
        idle();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gpio_v2.md
Name: gpio_v2

Overview:
- Parametrised GPIO peripheral on the SoC slave bus, replacing the fixed 10-pin GPIO.
- Adds per-pin mode control (hi-Z/output/input), input synchronisation, atomic set/clear of output data, and a per-pin edge interrupt with pending/enable registers and one combined irq line to the core.
- Register map is a superset of the old one: CTRL@0x00 and DATA@0x04 are unchanged, so existing software keeps working.

Parameters:
- NUM_IO, 10: number of pins, legal range 1..16.
- SYNC_STAGES, 2: input synchroniser depth, legal values 1 or 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- we_i  in  1  bus write strobe
- addr_i  in  32  bus address; only addr_i[4:0] is decoded
- data_i  in  32  bus write data
- data_o  out  32  bus read data, combinational
- io_pin_i  in  NUM_IO  raw pad inputs, asynchronous
- io_out_o  out  NUM_IO  pad output values
- io_oe_o  out  NUM_IO  pad output enables; pin i = 1 when mode 01
- reg_ctrl  out  32  CTRL register contents
- irq_o  out  1  |(IRQ_PEND & IRQ_EN)

Behaviour:
- Registers. All bits above the NUM_IO field read 0 and ignore writes.
  - 0x00 CTRL: 2 bits per pin. 00 hi-Z, 01 output, 10 input, 11 treated as hi-Z.
  - 0x04 DATA: RW.
  - 0x08 SET: write-1-sets DATA bits; reads 0.
  - 0x0C CLR: write-1-clears DATA bits; reads 0.
  - 0x10 IRQ_EN: per-pin interrupt enable.
  - 0x14 IRQ_TYPE: 2 bits per pin. 00 rising, 01 falling, 10 both edges, 11 disabled.
  - 0x18 IRQ_PEND: set by hardware; write-1-to-clear.
  - Unmapped offsets read 0; writes to them are ignored.
- Reset (rst=0, asynchronous):
  - All registers and synchroniser flops = 0.
  - io_out_o=0, io_oe_o=0, irq_o=0, data_o=0.
  - Reset asserted mid-operation clears all state immediately, including any pending interrupts.
- Outputs:
  - io_out_o[i] = DATA[i].
  - io_oe_o[i] = (CTRL[2i+1:2i]==01).
- Input path per pin:
  - Synchroniser chain s[1..SYNC_STAGES]; the synchronised value is sN.
  - History flop h <= sN every cycle.
  - Input-mode DATA bits load sN every cycle.
- Latency (SYNC_STAGES=2): a pin change sampled at edge k gives:
  - sN valid after edge k+1;
  - DATA bit and IRQ_PEND bit updated at edge k+2;
  - irq_o high after edge k+2.
  - Each SYNC_STAGES=1 removes one cycle.
- Edge detect: rise = sN & ~h; fall = ~sN & h. These are qualified by IRQ_TYPE and by the pin being in input mode.
  - Edges on pins not in input mode never set IRQ_PEND.
  - IRQ_PEND sets regardless of IRQ_EN; IRQ_EN only gates irq_o.
- Simultaneous events:
  - DATA write / SET / CLR vs input refresh: input-mode bits always take sN; write data applies only to output-mode and hi-Z bits.
  - SET and CLR are separate addresses, so they never coincide.
  - IRQ_PEND W1C in the same cycle as a new edge on that pin: the bit is set (set wins).
  - CTRL write changing a pin to input: the sN refresh starts the following cycle. A stale h does not cause a false edge, because h updates unconditionally.
- Reads: data_o is a combinational decode of addr_i[4:0]. No wait states.

Decomposition:
- Shared include gpio_defs: register offsets, mode encodings (HIZ/OUT/IN), IRQ_TYPE encodings, and the NUM_IO upper limit of 16.
- One sub-module, gpio_sync_edge, vectorised over NUM_IO. Parameter SYNC_STAGES. Inputs: clk, rst, pin vector. Outputs: sync value, rise, fall.

Test Plan:
- Reset/defaults: assert rst mid-run with DATA=0x3FF and IRQ_PEND nonzero -> all registers, io_oe_o, io_out_o and irq_o read 0 immediately, without waiting for a clk edge.
- Output SET/CLR: CTRL=0x55555 (all output), write SET=0x005, then CLR=0x001 -> DATA=0x004; io_out_o=0x004; io_oe_o=0x3FF.
- Input latency: CTRL[1:0]=10, raise io_pin_i[0] just before edge k -> DATA[0]=1 readable after edge k+2, not earlier; a DATA write of 0 to that bit is ignored.
- Rising IRQ: pin 3 input, IRQ_TYPE=00, IRQ_EN[3]=1, pulse pin 3 high -> IRQ_PEND=0x008 and irq_o=1 at k+2; W1C 0x008 -> irq_o=0 next cycle.
- Set-wins collision: pin 2 input with IRQ_TYPE=10 (both edges); W1C IRQ_PEND[2] in the exact cycle a falling edge registers -> IRQ_PEND[2] stays 1.
- Masking/mode: edge on a hi-Z pin -> IRQ_PEND unchanged. Edge on an input pin with IRQ_EN=0 -> IRQ_PEND bit set, irq_o stays 0; later setting IRQ_EN=1 -> irq_o=1.
